// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: data widths, pcsource
// codes, FSM state encoding, the default bubble instruction and a PC helper.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  // Default bubble instruction driven into ID when no valid fetch is present
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

  // Next-PC selection requested by ID
  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_JR  = 2'b10,
    PCS_J   = 2'b11
  } pcsource_e;

  // FETCH: response is wanted; DROP: response belongs to an abandoned request
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } if_state_e;

  // Sequential successor, 32-bit modulo
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold, or insert a bubble.
// Ports:
//   clk, clrn          clock, async active-low reset
//   i_load             capture i_inst / i_pc4 as a valid instruction
//   i_bubble           replace contents with NOP_INST, pc4 = 0, valid = 0
//   i_inst, i_pc4      fetched instruction and its pc+4
//   o_inst, o_pc4      registered instruction / pc+4 to ID
//   o_valid            registered valid flag to ID
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc4,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc4,
  output logic            o_valid
);

  // Load wins over bubble; neither asserted means hold
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      o_inst  <= NOP_INST;
      o_pc4   <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_inst  <= i_inst;
      o_pc4   <= i_pc4;
      o_valid <= 1'b1;
    end else if (i_bubble) begin
      o_inst  <= NOP_INST;
      o_pc4   <= '0;
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with a single outstanding imem request. Redirects
// that arrive while a request is in flight park the target in pend_pc and
// discard the stale response (DROP state) before fetching the new target.
// Ports:
//   clk, clrn                 clock, async active-low reset
//   pcsource, bpc, rpc, jpc   next-PC select and redirect targets from ID
//   stall                     load-use stall; freezes pc, pend_pc and IF/ID
//   imem_req, imem_addr       fetch request (registered)
//   imem_rdata, imem_ready    fetch response
//   id_inst, id_pc4, id_valid IF/ID pipeline register
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] rpc,
  input  logic [XLEN-1:0] jpc,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc4,
  output logic            id_valid
);

  if_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_req;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc4;
  logic            w_rdy;
  logic            w_load;
  logic            w_bubble;

  // A stall masks pcsource entirely
  assign w_redirect = !stall && (pcsource != PCS_SEQ);
  assign w_pc4      = pc_plus4(r_pc);
  // A response is only meaningful while a request is being driven
  assign w_rdy      = imem_ready && r_req;

  // Redirect target mux
  always_comb begin
    w_target = bpc;
    case (pcsource)
      PCS_BR:  w_target = bpc;
      PCS_JR:  w_target = rpc;
      PCS_J:   w_target = jpc;
      default: w_target = bpc;
    endcase
  end

  // IF/ID control: only an accepted, wanted, non-redirected response loads
  always_comb begin
    w_load   = 1'b0;
    w_bubble = 1'b0;
    if (r_req && !stall) begin
      if (r_state == ST_FETCH && w_rdy && !w_redirect) w_load   = 1'b1;
      else                                             w_bubble = 1'b1;
    end
  end

  // Fetch FSM, PC and pending-target registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_req     <= 1'b0;
    end else begin
      r_req <= 1'b1;
      if (r_req) begin
        case (r_state)
          ST_FETCH: begin
            // Under stall a response is dropped and the same pc re-fetched
            if (!stall) begin
              if (w_rdy) begin
                r_pc <= w_redirect ? w_target : w_pc4;
              end else if (w_redirect) begin
                r_pend_pc <= w_target;
                r_state   <= ST_DROP;
              end
            end
          end
          ST_DROP: begin
            // r_pc still holds the abandoned address, keeping imem_addr stable
            if (w_rdy) begin
              r_pc    <= w_redirect ? w_target : r_pend_pc;
              r_state <= ST_FETCH;
            end else if (w_redirect) begin
              r_pend_pc <= w_target;
            end
          end
          default: r_state <= ST_FETCH;
        endcase
      end
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk      (clk),
    .clrn     (clrn),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_inst   (imem_rdata),
    .i_pc4    (w_pc4),
    .o_inst   (id_inst),
    .o_pc4    (id_pc4),
    .o_valid  (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a transaction-level fetch model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: address in flight, whether its response is wanted,
  // where to go once an unwanted response returns, and the IF/ID contents
  logic [31:0] m_addr, m_next, m_inst, m_pc4;
  logic        m_wanted, m_valid, m_req;

  // Memory model: one request at a time, random latency
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;

  if_stage #(
    .RESET_PC (RST_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .id_inst    (id_inst),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr   = RST_PC;
    m_next   = '0;
    m_wanted = 1'b1;
    m_inst   = NOP;
    m_pc4    = '0;
    m_valid  = 1'b0;
    m_req    = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("id_inst",   id_inst,         m_inst);
    check_eq("id_pc4",    id_pc4,          m_pc4);
    check_eq("id_valid",  32'(id_valid),   32'(m_valid));
    check_eq("imem_req",  32'(imem_req),   32'(m_req));
    check_eq("imem_addr", imem_addr,       m_addr);
  endtask

  task automatic set_bubble();
    m_inst  = NOP;
    m_pc4   = '0;
    m_valid = 1'b0;
  endtask

  // One clock edge of the fetch model, given the inputs seen at that edge
  task automatic model_edge(input logic [1:0] pcs, input logic stl,
                            input logic [31:0] tgt, input logic rdy);
    bit redir;
    redir = !stl && (pcs != 2'b00);
    if (!m_req) begin
      m_req = 1'b1;
      return;
    end
    if (m_wanted) begin
      if (stl) begin
        // everything frozen; any response is simply refetched
      end else if (rdy && !redir) begin
        m_inst  = mem_word(m_addr);
        m_pc4   = m_addr + 32'd4;
        m_valid = 1'b1;
        m_addr  = m_addr + 32'd4;
      end else if (rdy) begin
        set_bubble();
        m_addr = tgt;
      end else begin
        set_bubble();
        if (redir) begin
          m_wanted = 1'b0;
          m_next   = tgt;
        end
      end
    end else begin
      if (!stl) set_bubble();
      if (rdy) begin
        m_addr   = redir ? tgt : m_next;
        m_wanted = 1'b1;
      end else if (redir) begin
        m_next = tgt;
      end
    end
  endtask

  // Called at a negedge: check, drive, clock, update model, return at negedge
  task automatic step(input logic [1:0] pcs, input logic stl, input logic [31:0] tgt,
                      input int max_lat, input bit hold);
    logic [31:0] r;
    check_outputs();
    pcsource = pcs;
    stall    = stl;
    r = $urandom(); bpc = r & 32'hFFFF_FFFC;
    r = $urandom(); rpc = r & 32'hFFFF_FFFC;
    r = $urandom(); jpc = r & 32'hFFFF_FFFC;
    case (pcs)
      2'b01:   bpc = tgt;
      2'b10:   rpc = tgt;
      2'b11:   jpc = tgt;
      default: ;
    endcase
    if (!imem_req) begin
      imem_ready = 1'b0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_wait = int'($urandom_range(max_lat, 0));
      end else begin
        check_eq("addr_stable", imem_addr, mem_addr);
      end
      imem_ready = !hold && (max_lat == 0 || mem_wait == 0);
      if (imem_ready) mem_busy = 1'b0;
      else if (mem_wait != 0) mem_wait--;
    end
    imem_rdata = mem_word(imem_addr);
    @(posedge clk);
    model_edge(pcs, stl, tgt, imem_ready);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  pcs;
    logic        stl;
    logic [31:0] tgt;

    clrn = 1'b0; pcsource = 2'b00; bpc = '0; rpc = '0; jpc = '0;
    stall = 1'b0; imem_rdata = '0; imem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    clrn = 1'b1;

    // Zero-wait sequential fetch from reset
    repeat (8) step(2'b00, 1'b0, '0, 0, 1'b0);

    // Branch with immediate response, then sequential
    step(2'b01, 1'b0, 32'h40, 0, 1'b0);
    step(2'b00, 1'b0, '0, 0, 1'b0);
    step(2'b00, 1'b0, '0, 0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      pcs = ($urandom_range(9, 0) < 2) ? 2'($urandom_range(3, 1)) : 2'b00;
      stl = ($urandom_range(6, 0) == 0);
      r   = $urandom();
      tgt = ($urandom_range(15, 0) == 0) ? 32'hFFFF_FFFC : (r & 32'hFFFF_FFFC);
      step(pcs, stl, tgt, 3, 1'b0);
    end

    // Settle, then wrap-around at the top of the address space
    repeat (3) step(2'b00, 1'b0, '0, 0, 1'b0);
    step(2'b11, 1'b0, 32'hFFFF_FFFC, 0, 1'b0);
    step(2'b00, 1'b0, '0, 0, 1'b0);
    check_eq("wrap_pc4",   id_pc4,         32'h0);
    check_eq("wrap_valid", 32'(id_valid),  32'h1);
    check_eq("wrap_addr",  imem_addr,      32'h0);

    // Jump while the current request waits three cycles
    step(2'b00, 1'b0, '0, 0, 1'b0);
    step(2'b11, 1'b0, 32'h100, 0, 1'b1);
    step(2'b00, 1'b0, '0, 0, 1'b1);
    step(2'b00, 1'b0, '0, 0, 1'b1);
    step(2'b00, 1'b0, '0, 0, 1'b0);
    check_eq("drop_valid", 32'(id_valid), 32'h0);
    check_eq("drop_addr",  imem_addr,     32'h100);

    // Stall with a jump requested: jump ignored, pc re-issued
    step(2'b00, 1'b0, '0, 0, 1'b0);
    step(2'b11, 1'b1, 32'h200, 0, 1'b0);
    step(2'b11, 1'b1, 32'h200, 0, 1'b0);
    step(2'b00, 1'b0, '0, 0, 1'b0);

    // Reset pulse while in DROP
    step(2'b00, 1'b0, '0, 0, 1'b1);
    step(2'b11, 1'b0, 32'h300, 0, 1'b1);
    step(2'b00, 1'b0, '0, 0, 1'b1);
    #2 clrn = 1'b0;
    #1;
    check_eq("rst_inst",  id_inst,         NOP);
    check_eq("rst_pc4",   id_pc4,          32'h0);
    check_eq("rst_valid", 32'(id_valid),   32'h0);
    check_eq("rst_req",   32'(imem_req),   32'h0);
    check_eq("rst_addr",  imem_addr,       RST_PC);
    model_reset();
    imem_ready = 1'b0;
    pcsource   = 2'b00;
    @(negedge clk);
    clrn = 1'b1;
    repeat (4) step(2'b00, 1'b0, '0, 0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      pcs = ($urandom_range(4, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      stl = ($urandom_range(5, 0) == 0);
      r   = $urandom();
      step(pcs, stl, r & 32'hFFFF_FFFC, 2, 1'b0);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
